// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Optional timeout logic elsewhere is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} arb_state_t;
    typedef enum logic {GNT_IMEM, GNT_DMEM} grant_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    // Word wins over half wins over byte; no size bit set means word.
    function automatic size_t size_decode(input logic is_byte, input logic is_hwrd,
                                          input logic is_wrd);
        if (is_wrd) return SZ_WORD;
        if (is_hwrd) return SZ_HALF;
        if (is_byte) return SZ_BYTE;
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for writes, lane extraction and extension for reads,
// and misalignment detection for the data port.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_wsize,
    input  logic [1:0]  i_waddr_lo,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic        o_misalign,
    input  logic [1:0]  i_rsize,
    input  logic [1:0]  i_raddr_lo,
    input  logic        i_rdu,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    always_comb begin
        o_wdata    = i_wdata;
        o_wstrb    = 4'b1111;
        o_misalign = 1'b0;
        case (i_wsize)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wstrb = 4'b0001 << i_waddr_lo;
            end
            SZ_HALF: begin
                o_wdata    = {2{i_wdata[15:0]}};
                o_wstrb    = i_waddr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_waddr_lo[0];
            end
            default: o_misalign = |i_waddr_lo;
        endcase
    end

    always_comb begin
        w_rbyte = i_rdata[7:0];
        case (i_raddr_lo)
            2'd1:    w_rbyte = i_rdata[15:8];
            2'd2:    w_rbyte = i_rdata[23:16];
            2'd3:    w_rbyte = i_rdata[31:24];
            default: w_rbyte = i_rdata[7:0];
        endcase
        w_rhalf = i_raddr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_rsize)
            SZ_BYTE: o_rdata = {{24{~i_rdu & w_rbyte[7]}}, w_rbyte};
            SZ_HALF: o_rdata = {{16{~i_rdu & w_rhalf[15]}}, w_rhalf};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory port between fetch and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort transactions lacking mem_ack after TIMEOUT_CYCLES.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_read,
    output logic        o_imem_drdy,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_err,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic        i_dmem_write,
    input  logic        i_dmem_read,
    input  logic        i_dmem_rdu,
    input  logic        i_dmem_byte,
    input  logic        i_dmem_hwrd,
    input  logic        i_dmem_wrd,
    output logic        o_dmem_drdy,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    arb_state_t  r_state;
    grant_t      r_last;
    size_t       r_size;
    logic [1:0]  r_addr_lo;
    logic        r_rdu;
    logic        r_misalign;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_imem_drdy;
    logic [31:0] r_imem_rdata;
    logic        r_dmem_drdy;
    logic [31:0] r_dmem_rdata;
    logic        r_dmem_err;

    logic        w_dmem_pend;
    logic        w_pick_d;
    logic        w_ok;
    logic        w_timeout;
    size_t       w_d_size;
    logic [31:0] w_al_wdata;
    logic [3:0]  w_al_wstrb;
    logic        w_al_misalign;
    logic [31:0] w_al_rdata;
    logic [1:0]  w_unused_ilo;

    assign w_dmem_pend  = i_dmem_read | i_dmem_write;
    // Under contention the side that did not win last time goes first.
    assign w_pick_d     = w_dmem_pend & (~i_imem_read | (r_last == GNT_IMEM));
    assign w_d_size     = size_decode(i_dmem_byte, i_dmem_hwrd, i_dmem_wrd);
    assign w_ok         = i_mem_ack & ~r_misalign;
    assign w_unused_ilo = i_imem_addr[1:0];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] r_busy_cnt;
    logic            r_imem_err;

    assign w_timeout  = (r_busy_cnt == CntW'(TIMEOUT_CYCLES - 1));
    assign o_imem_err = r_imem_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign o_imem_err       = 1'b0;
`endif

    mem_lane_align u_align (
        .i_wsize    (w_d_size),
        .i_waddr_lo (i_dmem_addr[1:0]),
        .i_wdata    (i_dmem_wdata),
        .o_wdata    (w_al_wdata),
        .o_wstrb    (w_al_wstrb),
        .o_misalign (w_al_misalign),
        .i_rsize    (r_size),
        .i_raddr_lo (r_addr_lo),
        .i_rdu      (r_rdu),
        .i_rdata    (i_mem_rdata),
        .o_rdata    (w_al_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last       <= GNT_IMEM;
            r_size       <= SZ_BYTE;
            r_addr_lo    <= 2'b00;
            r_rdu        <= 1'b0;
            r_misalign   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_imem_drdy  <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_drdy  <= 1'b0;
            r_dmem_rdata <= '0;
            r_dmem_err   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_busy_cnt   <= '0;
            r_imem_err   <= 1'b0;
`endif
        end else begin
            r_imem_drdy <= 1'b0;
            r_dmem_drdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state     <= DBUSY;
                        r_last      <= GNT_DMEM;
                        r_size      <= w_d_size;
                        r_addr_lo   <= i_dmem_addr[1:0];
                        r_rdu       <= i_dmem_rdu;
                        r_misalign  <= w_al_misalign;
                        r_mem_req   <= ~w_al_misalign;
                        r_mem_we    <= i_dmem_write;
                        r_mem_addr  <= {i_dmem_addr[31:2], 2'b00};
                        r_mem_wdata <= w_al_wdata;
                        r_mem_wstrb <= i_dmem_write ? w_al_wstrb : 4'b0000;
                    end else if (i_imem_read) begin
                        r_state     <= IBUSY;
                        r_last      <= GNT_IMEM;
                        r_size      <= SZ_WORD;
                        r_addr_lo   <= 2'b00;
                        r_misalign  <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {i_imem_addr[31:2], 2'b00};
                        r_mem_wdata <= '0;
                        r_mem_wstrb <= 4'b0000;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    r_busy_cnt <= '0;
`endif
                end
                IBUSY, DBUSY: begin
                    // A misaligned access completes as if acked, with an error.
                    if (r_misalign || i_mem_ack || w_timeout) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        if (r_state == IBUSY) begin
                            r_imem_drdy  <= 1'b1;
                            r_imem_rdata <= w_ok ? i_mem_rdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_imem_err   <= ~w_ok;
`endif
                        end else begin
                            r_dmem_drdy  <= 1'b1;
                            r_dmem_rdata <= (w_ok && !r_mem_we) ? w_al_rdata : '0;
                            r_dmem_err   <= ~w_ok;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    r_busy_cnt <= r_busy_cnt + CntW'(1);
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_imem_drdy  = r_imem_drdy;
    assign o_imem_rdata = r_imem_rdata;
    assign o_dmem_drdy  = r_dmem_drdy;
    assign o_dmem_rdata = r_dmem_rdata;
    assign o_dmem_err   = r_dmem_err;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; covers the timeout path when
// MEM_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_drdy;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_write;
    logic        dmem_read;
    logic        dmem_rdu;
    logic        dmem_byte;
    logic        dmem_hwrd;
    logic        dmem_wrd;
    logic        dmem_drdy;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Observations of the last transaction driven by run_txn.
    int          t_lat;
    int          t_req_cnt;
    logic        t_got;
    logic        t_saw_req;
    logic        t_mwe;
    logic        t_err;
    logic [31:0] t_maddr;
    logic [31:0] t_mwdata;
    logic [31:0] t_rdata;
    logic [3:0]  t_mstrb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_imem_addr  (imem_addr),
        .i_imem_read  (imem_read),
        .o_imem_drdy  (imem_drdy),
        .o_imem_rdata (imem_rdata),
        .o_imem_err   (imem_err),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_wdata (dmem_wdata),
        .i_dmem_write (dmem_write),
        .i_dmem_read  (dmem_read),
        .i_dmem_rdu   (dmem_rdu),
        .i_dmem_byte  (dmem_byte),
        .i_dmem_hwrd  (dmem_hwrd),
        .i_dmem_wrd   (dmem_wrd),
        .o_dmem_drdy  (dmem_drdy),
        .o_dmem_rdata (dmem_rdata),
        .o_dmem_err   (dmem_err),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wstrb  (mem_wstrb),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic clear_inputs();
        imem_addr = '0; imem_read = 0;
        dmem_addr = '0; dmem_wdata = '0; dmem_write = 0; dmem_read = 0; dmem_rdu = 0;
        dmem_byte = 0; dmem_hwrd = 0; dmem_wrd = 0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one request, act as memory acking ack_dly cycles after mem_req (-1: never).
    task automatic run_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] sz, input logic rdu,
                           input int ack_dly, input logic [31:0] mrd);
        int start;
        int req_cyc;
        t_got = 0; t_saw_req = 0; t_req_cnt = 0; t_lat = -1; t_err = 0; t_rdata = '0;
        t_maddr = '0; t_mwdata = '0; t_mstrb = '0; t_mwe = 0; req_cyc = 0;
        @(posedge clk); #1;
        start = cyc;
        if (is_d) begin
            dmem_addr = addr; dmem_wdata = wd; dmem_write = wr; dmem_read = ~wr;
            {dmem_wrd, dmem_hwrd, dmem_byte} = sz; dmem_rdu = rdu;
        end else begin
            imem_addr = addr; imem_read = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((is_d ? dmem_drdy : imem_drdy) === 1'b1) begin
                t_got   = 1'b1;
                t_lat   = cyc - start;
                t_rdata = is_d ? dmem_rdata : imem_rdata;
                t_err   = is_d ? dmem_err : imem_err;
                break;
            end
            if (mem_req === 1'b1) begin
                if (!t_saw_req) begin
                    t_saw_req = 1'b1; req_cyc = cyc;
                    t_maddr = mem_addr; t_mwdata = mem_wdata; t_mstrb = mem_wstrb; t_mwe = mem_we;
                end
                t_req_cnt++;
            end
            mem_ack   = (ack_dly >= 0) && t_saw_req && (mem_req === 1'b1)
                        && (cyc - req_cyc == ack_dly);
            mem_rdata = mem_ack ? mrd : $urandom();
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req);
        end
        n_checks++;
        if ({imem_drdy, dmem_drdy} !== 2'b00) begin
            n_errors++; $display("FAIL reset_drdy: got %b want 00", {imem_drdy, dmem_drdy});
        end
        n_checks++;
        if ({imem_rdata, imem_err, dmem_rdata, dmem_err, mem_we, mem_addr, mem_wdata, mem_wstrb}
            !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got nonzero want all 0");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_imem_read();
        run_txn(1'b0, 1'b0, 32'h0000_0040, '0, 3'b000, 1'b0, 1, 32'hDEAD_BEEF);
        n_checks++;
        if (t_got !== 1'b1 || t_lat !== 3) begin
            n_errors++; $display("FAIL imem_latency: got drdy=%0b lat=%0d want 1/3", t_got, t_lat);
        end
        n_checks++;
        if (t_maddr !== 32'h40 || t_mwe !== 1'b0) begin
            n_errors++; $display("FAIL imem_addr_we: got %h/%0b want 00000040/0", t_maddr, t_mwe);
        end
        n_checks++;
        if (t_rdata !== 32'hDEAD_BEEF || t_err !== 1'b0) begin
            n_errors++; $display("FAIL imem_rdata: got %h err=%0b want deadbeef/0", t_rdata, t_err);
        end
    endtask

    task automatic test_contention();
        logic        exp_d;
        logic        last_d;
        logic        got_d;
        logic        done;
        logic        seen;
        logic [31:0] seen_addr;
        do_reset();
        @(posedge clk); #1;
        imem_addr = 32'h200; imem_read = 1'b1;
        dmem_addr = 32'h300; dmem_read = 1'b1; dmem_wrd = 1'b1;
        last_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_d = ~last_d;
            last_d = exp_d;
            got_d = 0; done = 0; seen = 0; seen_addr = '0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (dmem_drdy === 1'b1 || imem_drdy === 1'b1) begin
                    got_d = dmem_drdy; done = 1'b1; mem_ack = 1'b0;
                    break;
                end
                if (mem_req === 1'b1 && !seen) begin
                    seen = 1'b1; seen_addr = mem_addr;
                end
                mem_ack = (mem_req === 1'b1);
            end
            n_checks++;
            if (done !== 1'b1 || got_d !== exp_d) begin
                n_errors++;
                $display("FAIL contention_grant_%0d: got done=%0b dside=%0b want 1/%0b",
                         k, done, got_d, exp_d);
            end
            n_checks++;
            if (seen_addr !== (exp_d ? 32'h300 : 32'h200)) begin
                n_errors++;
                $display("FAIL contention_addr_%0d: got %h want %h", k, seen_addr,
                         exp_d ? 32'h300 : 32'h200);
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_byte_write();
        run_txn(1'b1, 1'b1, 32'h0000_0103, 32'h1234_56A5, 3'b001, 1'b0, 1, '0);
        n_checks++;
        if (t_got !== 1'b1 || t_maddr !== 32'h100 || t_mwe !== 1'b1) begin
            n_errors++;
            $display("FAIL byte_write_addr: got drdy=%0b addr=%h we=%0b want 1/00000100/1",
                     t_got, t_maddr, t_mwe);
        end
        n_checks++;
        if (t_mstrb !== 4'b1000 || t_mwdata !== 32'hA5A5_A5A5) begin
            n_errors++;
            $display("FAIL byte_write_lanes: got strb=%b data=%h want 1000/a5a5a5a5",
                     t_mstrb, t_mwdata);
        end
    endtask

    task automatic test_half_read();
        run_txn(1'b1, 1'b0, 32'h0000_0102, '0, 3'b010, 1'b0, 1, 32'h8001_0000);
        n_checks++;
        if (t_rdata !== 32'hFFFF_8001 || t_err !== 1'b0 || t_mstrb !== 4'b0000) begin
            n_errors++;
            $display("FAIL half_read_sext: got %h err=%0b strb=%b want ffff8001/0/0000",
                     t_rdata, t_err, t_mstrb);
        end
        run_txn(1'b1, 1'b0, 32'h0000_0102, '0, 3'b010, 1'b1, 0, 32'h8001_0000);
        n_checks++;
        if (t_rdata !== 32'h0000_8001 || t_lat !== 2 || t_maddr !== 32'h100) begin
            n_errors++;
            $display("FAIL half_read_zext: got %h lat=%0d addr=%h want 00008001/2/00000100",
                     t_rdata, t_lat, t_maddr);
        end
    endtask

    task automatic test_misalign();
        run_txn(1'b1, 1'b0, 32'h0000_0006, '0, 3'b100, 1'b0, 0, 32'h1111_1111);
        n_checks++;
        if (t_got !== 1'b1 || t_lat !== 2 || t_saw_req !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_timing: got drdy=%0b lat=%0d req=%0b want 1/2/0",
                     t_got, t_lat, t_saw_req);
        end
        n_checks++;
        if (t_err !== 1'b1 || t_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL misalign_result: got err=%0b rdata=%h want 1/00000000", t_err, t_rdata);
        end
    endtask

    task automatic test_random();
        logic        is_d, wr, rdu, misal;
        logic [2:0]  szb;
        logic [31:0] addr, wd, mrd, e_wdata, e_rdata, sh;
        logic [3:0]  e_strb;
        int          sz, lane, dly, e_lat;
        for (int n = 0; n < 40; n++) begin
            is_d = ($urandom_range(3) != 0);
            wr   = $urandom_range(1);
            rdu  = $urandom_range(1);
            szb  = 3'($urandom_range(7));
            addr = $urandom();
            wd   = $urandom();
            mrd  = $urandom();
            dly  = $urandom_range(4);
            // Reference: size priority, lane math on plain integers.
            sz    = !is_d ? 2 : szb[2] ? 2 : szb[1] ? 1 : szb[0] ? 0 : 2;
            lane  = is_d ? int'(addr[1:0]) : 0;
            misal = is_d && ((sz == 1 && lane % 2 == 1) || (sz == 2 && lane != 0));
            e_lat = misal ? 2 : 2 + dly;
            if (sz == 0) begin
                e_wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
                e_strb  = 4'(1 << lane);
                sh      = (mrd >> (8 * lane)) & 32'hFF;
                e_rdata = (!rdu && sh[7]) ? (sh | 32'hFFFF_FF00) : sh;
            end else if (sz == 1) begin
                e_wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
                e_strb  = (lane >= 2) ? 4'hC : 4'h3;
                sh      = (mrd >> (16 * (lane / 2))) & 32'hFFFF;
                e_rdata = (!rdu && sh[15]) ? (sh | 32'hFFFF_0000) : sh;
            end else begin
                e_wdata = wd;
                e_strb  = 4'hF;
                e_rdata = mrd;
            end
            if (!is_d || !wr) e_strb = 4'h0;
            if (misal) e_rdata = '0;
            run_txn(is_d, is_d & wr, addr, wd, szb, rdu, dly, mrd);
            n_checks++;
            if (t_got !== 1'b1 || t_lat !== e_lat || t_saw_req !== !misal) begin
                n_errors++;
                $display("FAIL rand_%0d_timing: got drdy=%0b lat=%0d req=%0b want 1/%0d/%0b",
                         n, t_got, t_lat, t_saw_req, e_lat, !misal);
            end
            n_checks++;
            if (t_err !== misal) begin
                n_errors++; $display("FAIL rand_%0d_err: got %0b want %0b", n, t_err, misal);
            end
            if (!misal) begin
                n_checks++;
                if (t_maddr !== {addr[31:2], 2'b00} || t_mwe !== (is_d & wr)
                    || t_mstrb !== e_strb) begin
                    n_errors++;
                    $display("FAIL rand_%0d_req: got addr=%h we=%0b strb=%b want %h/%0b/%b",
                             n, t_maddr, t_mwe, t_mstrb, {addr[31:2], 2'b00}, is_d & wr, e_strb);
                end
                n_checks++;
                if (is_d && wr) begin
                    if (t_mwdata !== e_wdata) begin
                        n_errors++;
                        $display("FAIL rand_%0d_wdata: got %h want %h", n, t_mwdata, e_wdata);
                    end
                end else if (t_rdata !== e_rdata) begin
                    n_errors++;
                    $display("FAIL rand_%0d_rdata: got %h want %h", n, t_rdata, e_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_midbusy();
        logic seen;
        int   drdy_cnt;
        @(posedge clk); #1;
        imem_addr = 32'h80; imem_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++; $display("FAIL midreset_req_seen: got %0b want 1", seen);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++; $display("FAIL midreset_async_drop: got %0b want 0", mem_req);
        end
        imem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drdy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_drdy === 1'b1 || dmem_drdy === 1'b1) drdy_cnt++;
        end
        n_checks++;
        if (drdy_cnt !== 0) begin
            n_errors++; $display("FAIL midreset_no_drdy: got %0d pulses want 0", drdy_cnt);
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int late;
        run_txn(1'b1, 1'b0, 32'h0000_0010, '0, 3'b100, 1'b0, -1, '0);
        n_checks++;
        if (t_req_cnt !== 8 || t_got !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_busy_cycles: got req=%0d drdy=%0b want 8/1", t_req_cnt, t_got);
        end
        n_checks++;
        if (t_err !== 1'b1 || t_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL timeout_result: got err=%0b rdata=%h want 1/00000000", t_err, t_rdata);
        end
        mem_ack = 1'b1;
        late = 0;
        repeat (3) begin
            @(negedge clk);
            if (dmem_drdy === 1'b1 || imem_drdy === 1'b1 || mem_req === 1'b1) late++;
        end
        mem_ack = 1'b0;
        n_checks++;
        if (late !== 0) begin
            n_errors++; $display("FAIL timeout_late_ack: got %0d events want 0", late);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_imem_read();
        test_contention();
        test_byte_write();
        test_half_read();
        test_misalign();
        test_random();
        test_reset_midbusy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
